// File: rtl/intr_controller.sv
// Edge-detected, masked, fixed-priority interrupt controller with single-level in-service tracking.
// Latency: IRQ edge -> pending +1 clk -> intr_req +1 clk at a boundary; no backpressure, requests are held until ack or withdrawn.
module intr_controller #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               intr_en,
    input  logic [31:0]        intr_vec,
    input  logic               boundary,
    input  logic [31:0]        cur_pc,
    input  logic               intr_ack,
    input  logic               intr_ret,
    output logic               intr_req,
    output logic [31:0]        intr_pc,
    output logic [CAUSE_W-1:0] intr_cause,
    output logic [31:0]        epc,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    localparam int PAD_W = 30 - CAUSE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, mask_q, prev_irq_q;
    logic [NUM_SRC-1:0] eligible, rise, clr;
    logic [CAUSE_W-1:0] cause_q, cause_d, winner;
    logic [31:0]        epc_q, epc_d;

    assign eligible = pending_q & mask_q;
    assign rise     = src_irq & ~prev_irq_q;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = (state_q == ST_REQ) && intr_ack && (cause_q == CAUSE_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            ST_IDLE: begin
                if (intr_en && boundary && (|eligible)) begin
                    state_d = ST_REQ;
                    cause_d = winner;
                    epc_d   = cur_pc;
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as intr_en dropping still takes the trap.
                if (intr_ack) begin
                    state_d = ST_SERVICE;
                end else if (!intr_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (intr_ret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            mask_q     <= '1;
            prev_irq_q <= '1;
            cause_q    <= '0;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= (pending_q & ~clr) | rise;
            prev_irq_q <= src_irq;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign intr_req   = (state_q == ST_REQ);
    assign in_service = (state_q == ST_SERVICE);
    assign intr_cause = cause_q;
    assign epc        = epc_q;
    assign pending    = pending_q;
    assign intr_pc    = intr_vec + {{PAD_W{1'b0}}, cause_q, 2'b00};

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed scenarios plus random traffic, all checked cycle by cycle
// against a reference model through an expected-value queue.
module tb_intr_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        intr_en;
    logic [31:0] intr_vec;
    logic        boundary;
    logic [31:0] cur_pc;
    logic        intr_ack;
    logic        intr_ret;
    logic        intr_req;
    logic [31:0] intr_pc;
    logic [3:0]  intr_cause;
    logic [31:0] epc;
    logic        in_service;
    logic [3:0]  pending;

    intr_controller #(.NUM_SRC(4), .CAUSE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_irq    (src_irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .intr_en    (intr_en),
        .intr_vec   (intr_vec),
        .boundary   (boundary),
        .cur_pc     (cur_pc),
        .intr_ack   (intr_ack),
        .intr_ret   (intr_ret),
        .intr_req   (intr_req),
        .intr_pc    (intr_pc),
        .intr_cause (intr_cause),
        .epc        (epc),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        svc;
        logic [3:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the interrupt bookkeeping as described, with the
    // trap lifecycle kept as two flags (request outstanding, handler running).
    logic [3:0]  m_pend, m_mask, m_prev, m_cause;
    logic [31:0] m_epc;
    bit          m_req, m_svc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Applies the inputs currently driven to the model, queues the expected
    // outputs for after the coming edge, then advances to the next falling edge.
    task automatic tick();
        logic [3:0] rise, elig, clr;
        exp_t e;
        if (reset) begin
            m_pend = 4'h0; m_mask = 4'hF; m_prev = 4'hF;
            m_req = 0; m_svc = 0; m_cause = 4'h0; m_epc = 32'h0;
        end else begin
            rise = src_irq & ~m_prev;
            elig = m_pend & m_mask;
            clr  = 4'h0;
            if (m_req) begin
                if (intr_ack) begin
                    clr[m_cause[1:0]] = 1'b1;
                    m_req = 0;
                    m_svc = 1;
                end else if (!intr_en) begin
                    m_req = 0;
                end
            end else if (m_svc) begin
                if (intr_ret) m_svc = 0;
            end else if (intr_en && boundary && elig != 4'h0) begin
                m_req   = 1;
                m_cause = first_set(elig);
                m_epc   = cur_pc;
            end
            m_pend = (m_pend & ~clr) | rise;
            m_prev = src_irq;
            if (mask_we) m_mask = mask_wdata;
        end
        e.req   = m_req;
        e.cause = m_cause;
        e.pc    = intr_vec + 32'(m_cause) * 32'd4;
        e.epc   = m_epc;
        e.svc   = m_svc;
        e.pend  = m_pend;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: one expected record per clock, compared shortly after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("intr_req",   32'(intr_req),   32'(e.req));
                chk("intr_cause", 32'(intr_cause), 32'(e.cause));
                chk("intr_pc",    intr_pc,         e.pc);
                chk("epc",        epc,             e.epc);
                chk("in_service", 32'(in_service), 32'(e.svc));
                chk("pending",    32'(pending),    32'(e.pend));
            end
        end
    end

    initial begin
        int k;
        reset = 1; src_irq = 4'hF; mask_we = 0; mask_wdata = 4'h0; intr_en = 0;
        intr_vec = 32'h0; boundary = 0; cur_pc = 32'h0; intr_ack = 0; intr_ret = 0;

        // 1: lines high through reset are not edges; a fresh edge on src[1] is
        ticks(2);
        reset = 0; ticks(2);
        chk("t1_no_pend", 32'(pending), 32'h0);
        src_irq = 4'hD; tick();
        src_irq = 4'hF; tick();
        chk("t1_pend", 32'(pending), 32'h2);

        // 2: basic request, vector and ack
        reset = 1; tick();
        reset = 0; src_irq = 4'h0; tick();
        intr_en = 1; intr_vec = 32'h100; boundary = 1; cur_pc = 32'h40;
        src_irq = 4'h4; tick();
        tick();
        chk("t2_req", 32'(intr_req), 32'h1);
        chk("t2_cause", 32'(intr_cause), 32'h2);
        chk("t2_pc", intr_pc, 32'h108);
        chk("t2_epc", epc, 32'h40);
        intr_ack = 1; tick();
        intr_ack = 0;
        chk("t2_pend_clr", 32'(pending[2]), 32'h0);
        chk("t2_insvc", 32'(in_service), 32'h1);
        intr_ret = 1; tick();
        intr_ret = 0;

        // 3: simultaneous edges served in priority order
        src_irq = 4'hE; tick();
        tick();
        chk("t3_cause1", 32'(intr_cause), 32'h1);
        intr_ack = 1; tick(); intr_ack = 0;
        intr_ret = 1; tick(); intr_ret = 0;
        tick();
        chk("t3_cause3", 32'(intr_cause), 32'h3);
        chk("t3_req3", 32'(intr_req), 32'h1);
        intr_ack = 1; tick(); intr_ack = 0;
        intr_ret = 1; tick(); intr_ret = 0;

        // 4: masked source stays pending until unmasked
        src_irq = 4'h0; tick();
        mask_we = 1; mask_wdata = 4'hE; tick(); mask_we = 0;
        src_irq = 4'h1; ticks(3);
        chk("t4_no_req", 32'(intr_req), 32'h0);
        chk("t4_pend0", 32'(pending[0]), 32'h1);
        mask_we = 1; mask_wdata = 4'hF; tick(); mask_we = 0;
        tick();
        chk("t4_cause0", 32'(intr_cause), 32'h0);
        chk("t4_req", 32'(intr_req), 32'h1);
        intr_ack = 1; tick(); intr_ack = 0;
        intr_ret = 1; tick(); intr_ret = 0;

        // 5: withdraw on intr_en drop, then re-request
        src_irq = 4'h0; tick();
        src_irq = 4'h2; tick();
        tick();
        intr_en = 0; tick();
        chk("t5_withdrawn", 32'(intr_req), 32'h0);
        chk("t5_pend_kept", 32'(pending[1]), 32'h1);
        intr_en = 1; tick();
        chk("t5_rereq_cause", 32'(intr_cause), 32'h1);
        intr_ack = 1; tick(); intr_ack = 0;
        intr_ret = 1; tick(); intr_ret = 0;

        // 6: no nesting in service, then reset mid-request
        src_irq = 4'h0; tick();
        src_irq = 4'h4; tick();
        tick();
        intr_ack = 1; tick(); intr_ack = 0;
        src_irq = 4'h5; ticks(2);
        chk("t6_no_nest", 32'(intr_req), 32'h0);
        chk("t6_pend0", 32'(pending[0]), 32'h1);
        intr_ret = 1; tick(); intr_ret = 0;
        tick();
        chk("t6_req0", 32'(intr_req), 32'h1);
        reset = 1; tick(); reset = 0;
        chk("t6_rst_req", 32'(intr_req), 32'h0);
        chk("t6_rst_pend", 32'(pending), 32'h0);
        chk("t6_rst_epc", epc, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 3));
                src_irq[k] = ~src_irq[k];
            end
            intr_en    = ($urandom_range(0, 7) != 0);
            boundary   = ($urandom_range(0, 1) == 1);
            cur_pc     = $urandom;
            if ($urandom_range(0, 49) == 0) intr_vec = $urandom;
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            intr_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            intr_ret   = m_svc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            tick();
        end

        reset = 0; intr_ack = 0; intr_ret = 0; mask_we = 0;
        @(posedge clk); #2;
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
